// File: rtl/pinmux_cfg_mux.sv
// Register-configured pad multiplexer: per-pad function select with GPIO fallback,
// select-change output guard, and synchronised, optionally glitch-filtered pad inputs.
module pinmux_cfg_mux #(
   parameter int unsigned NPAD  = 38,
   parameter int unsigned NFUNC = 4,
   parameter int unsigned FW    = 4
) (
   input  logic                  mclk,
   input  logic                  reset,
   input  logic                  reg_cs,
   input  logic                  reg_wr,
   input  logic [7:0]            reg_addr,
   input  logic [31:0]           reg_wdata,
   input  logic [3:0]            reg_be,
   output logic [31:0]           reg_rdata,
   output logic                  reg_ack,
   input  logic [NFUNC*NPAD-1:0] func_out,
   input  logic [NFUNC*NPAD-1:0] func_oeb,
   output logic [NPAD-1:0]       pad_in,
   input  logic [NPAD-1:0]       io_in,
   output logic [NPAD-1:0]       io_out,
   output logic [NPAD-1:0]       io_oeb
);
   localparam int unsigned SelW = FW * NPAD;

   logic                 ack_q;
   logic [31:0]          rdata_q, rdata_d;
   logic                 global_en_q, global_en_d;
   logic [7:0]           presc_q, presc_d;
   logic                 lock_q, lock_d;
   logic [SelW-1:0]      sel_q, sel_d;
   logic [NPAD-1:0]      gout_q, gout_d, goe_q, goe_d, fen_q, fen_d;
   logic [NPAD-1:0][1:0] guard_q, guard_d;
   logic [NPAD-1:0]      sync1_q, sync2_q, filt_q, filt_d;
   logic [NPAD-1:0][1:0] hist_q, hist_d;
   logic [7:0]           pcnt_q, pcnt_d;
   logic                 tick;
   logic                 acc, wr;
   logic [5:0]           widx;
   logic [2:0]           sidx;
   logic [31:0]          wmask;
   logic [255:0]         sel_ext;
   logic [63:0]          gout_ext, goe_ext, fen_ext, pin_ext;
   logic                 unused_addr;

   assign unused_addr = ^reg_addr[1:0];
   assign acc      = reg_cs & ~ack_q;
   assign wr       = acc & reg_wr;
   assign widx     = reg_addr[7:2];
   assign sidx     = 3'(widx - 6'd4);
   assign wmask    = {{8{reg_be[3]}}, {8{reg_be[2]}}, {8{reg_be[1]}}, {8{reg_be[0]}}};
   assign sel_ext  = 256'(sel_q);
   assign gout_ext = 64'(gout_q);
   assign goe_ext  = 64'(goe_q);
   assign fen_ext  = 64'(fen_q);
   assign pin_ext  = 64'(pad_in);
   assign reg_ack   = ack_q;
   assign reg_rdata = rdata_q;

   // Register writes; per-pad loops keep bits of absent pads out of the state entirely.
   always_comb begin
      global_en_d = global_en_q;
      presc_d     = presc_q;
      lock_d      = lock_q;
      sel_d       = sel_q;
      gout_d      = gout_q;
      goe_d       = goe_q;
      fen_d       = fen_q;
      if (wr && widx == 6'd0 && !lock_q) begin
         if (reg_be[0]) global_en_d = reg_wdata[0];
         if (reg_be[1]) presc_d = reg_wdata[15:8];
      end
      if (wr && widx == 6'd1 && reg_be[0] && reg_wdata[7:0] == 8'hA5) lock_d = 1'b1;
      for (int k = 0; k < NPAD; k++) begin
         if (wr && !lock_q && widx == 6'(4 + k / 8) && reg_be[(k % 8) / 2])
            sel_d[k*FW +: FW] = reg_wdata[(k % 8) * FW +: FW];
         if (wr && wmask[k % 32]) begin
            if (widx == 6'(12 + k / 32)) gout_d[k] = reg_wdata[k % 32];
            if (widx == 6'(14 + k / 32)) goe_d[k] = reg_wdata[k % 32];
            if (widx == 6'(18 + k / 32)) fen_d[k] = reg_wdata[k % 32];
         end
      end
   end

   always_comb begin
      rdata_d = '0;
      if (acc && !reg_wr) begin
         case (widx)
            6'd0:    rdata_d = {16'd0, presc_q, 7'd0, global_en_q};
            6'd1:    rdata_d = {31'd0, lock_q};
            6'd12:   rdata_d = gout_ext[31:0];
            6'd13:   rdata_d = gout_ext[63:32];
            6'd14:   rdata_d = goe_ext[31:0];
            6'd15:   rdata_d = goe_ext[63:32];
            6'd16:   rdata_d = pin_ext[31:0];
            6'd17:   rdata_d = pin_ext[63:32];
            6'd18:   rdata_d = fen_ext[31:0];
            6'd19:   rdata_d = fen_ext[63:32];
            default: if (widx >= 6'd4 && widx <= 6'd11) rdata_d = sel_ext[{sidx, 5'd0} +: 32];
         endcase
      end
   end

   // A changed select holds the pad tri-stated for two cycles while the new function settles.
   always_comb begin
      for (int k = 0; k < NPAD; k++) begin
         if (sel_d[k*FW +: FW] != sel_q[k*FW +: FW]) guard_d[k] = 2'd2;
         else if (guard_q[k] != 2'd0)                guard_d[k] = guard_q[k] - 2'd1;
         else                                        guard_d[k] = guard_q[k];
      end
   end

   always_comb begin : p_mux
      int unsigned f;
      f      = 0;
      io_out = '0;
      io_oeb = '1;
      for (int k = 0; k < NPAD; k++) begin
         f = 32'(sel_q[k*FW +: FW]);
         if (f >= NFUNC) f = 0;
         if (f == 0) begin
            io_out[k] = gout_q[k];
            io_oeb[k] = ~goe_q[k];
         end else begin
            io_out[k] = func_out[f*NPAD + k];
            io_oeb[k] = func_oeb[f*NPAD + k];
         end
         if (!global_en_q || guard_q[k] != 2'd0) io_oeb[k] = 1'b1;
      end
   end

   // Filter accepts a new level only when the live sample and two stored ticks agree.
   always_comb begin
      tick   = (pcnt_q == presc_q);
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
      for (int k = 0; k < NPAD; k++) begin
         hist_d[k] = tick ? {hist_q[k][0], sync2_q[k]} : hist_q[k];
         filt_d[k] = filt_q[k];
         if (!fen_q[k]) filt_d[k] = sync2_q[k];
         else if (tick && hist_q[k][0] == sync2_q[k] && hist_q[k][1] == sync2_q[k])
            filt_d[k] = sync2_q[k];
      end
   end

   assign pad_in = (fen_q & filt_q) | (~fen_q & sync2_q);

   always_ff @(posedge mclk) begin
      if (reset) begin
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         global_en_q <= 1'b0;
         presc_q     <= '0;
         lock_q      <= 1'b0;
         sel_q       <= '0;
         gout_q      <= '0;
         goe_q       <= '0;
         fen_q       <= '0;
         guard_q     <= '0;
         sync1_q     <= '0;
         sync2_q     <= '0;
         filt_q      <= '0;
         hist_q      <= '0;
         pcnt_q      <= '0;
      end else begin
         ack_q       <= acc;
         rdata_q     <= rdata_d;
         global_en_q <= global_en_d;
         presc_q     <= presc_d;
         lock_q      <= lock_d;
         sel_q       <= sel_d;
         gout_q      <= gout_d;
         goe_q       <= goe_d;
         fen_q       <= fen_d;
         guard_q     <= guard_d;
         sync1_q     <= io_in;
         sync2_q     <= sync1_q;
         filt_q      <= filt_d;
         hist_q      <= hist_d;
         pcnt_q      <= pcnt_d;
      end
   end
endmodule

// File: tb/tb_pinmux_cfg_mux.sv
// Bench for pinmux_cfg_mux: directed bus/guard/lock/filter steps plus randomized register
// traffic checked against a per-pad array model of the register file and output mux.
module tb_pinmux_cfg_mux;
   localparam int NPAD  = 38;
   localparam int NFUNC = 4;

   logic                  mclk = 1'b0;
   logic                  reset = 1'b1;
   logic                  reg_cs = 1'b0;
   logic                  reg_wr = 1'b0;
   logic [7:0]            reg_addr = '0;
   logic [31:0]           reg_wdata = '0;
   logic [3:0]            reg_be = '0;
   logic [31:0]           reg_rdata;
   logic                  reg_ack;
   logic [NFUNC*NPAD-1:0] func_out = '0;
   logic [NFUNC*NPAD-1:0] func_oeb = '0;
   logic [NPAD-1:0]       pad_in;
   logic [NPAD-1:0]       io_in = '0;
   logic [NPAD-1:0]       io_out;
   logic [NPAD-1:0]       io_oeb;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] rd;

   // Reference model: one entry per pad, plus the control fields.
   bit         m_en, m_lock;
   logic [7:0] m_presc;
   int         m_sel[NPAD];
   int         m_chg[NPAD];
   bit         m_gout[NPAD], m_goe[NPAD], m_fen[NPAD];

   pinmux_cfg_mux #(.NPAD(NPAD), .NFUNC(NFUNC), .FW(4)) dut (
      .mclk(mclk), .reset(reset), .reg_cs(reg_cs), .reg_wr(reg_wr), .reg_addr(reg_addr),
      .reg_wdata(reg_wdata), .reg_be(reg_be), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
      .func_out(func_out), .func_oeb(func_oeb), .pad_in(pad_in), .io_in(io_in),
      .io_out(io_out), .io_oeb(io_oeb)
   );

   always #5 mclk = ~mclk;
   always @(posedge mclk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_en = 0; m_lock = 0; m_presc = '0;
      for (int k = 0; k < NPAD; k++) begin
         m_sel[k] = 0; m_chg[k] = -100; m_gout[k] = 0; m_goe[k] = 0; m_fen[k] = 0;
      end
   endtask

   task automatic mwrite(input int word, input logic [31:0] wd, input logic [3:0] be);
      int p;
      if (word == 0) begin
         if (!m_lock && be[0]) m_en = wd[0];
         if (!m_lock && be[1]) m_presc = wd[15:8];
      end else if (word == 1) begin
         if (be[0] && wd[7:0] == 8'hA5) m_lock = 1;
      end else if (word >= 4 && word <= 11) begin
         for (int j = 0; j < 8; j++) begin
            p = (word - 4) * 8 + j;
            if (!m_lock && p < NPAD && be[j/2] && m_sel[p] != int'(wd[4*j +: 4])) begin
               m_sel[p] = int'(wd[4*j +: 4]);
               m_chg[p] = cyc;
            end
         end
      end else begin
         for (int b = 0; b < 32; b++) begin
            p = (word % 2) * 32 + b;
            if (p < NPAD && be[b/8]) begin
               case (word / 2)
                  6:       m_gout[p] = wd[b];
                  7:       m_goe[p] = wd[b];
                  9:       m_fen[p] = wd[b];
                  default: ;
               endcase
            end
         end
      end
   endtask

   function automatic logic [31:0] mread(input int word);
      logic [31:0] r;
      int p;
      r = '0;
      if (word == 0) r = {16'd0, m_presc, 7'd0, m_en};
      else if (word == 1) r[0] = m_lock;
      else if (word >= 4 && word <= 11) begin
         for (int j = 0; j < 8; j++) begin
            p = (word - 4) * 8 + j;
            if (p < NPAD) r[4*j +: 4] = 4'(m_sel[p]);
         end
      end else begin
         for (int b = 0; b < 32; b++) begin
            p = (word % 2) * 32 + b;
            if (p < NPAD) begin
               case (word / 2)
                  6:       r[b] = m_gout[p];
                  7:       r[b] = m_goe[p];
                  9:       r[b] = m_fen[p];
                  default: ;
               endcase
            end
         end
      end
      return r;
   endfunction

   // One bus access; returns #1 after the ack edge with cs already dropped.
   task automatic bus(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rdo);
      int n;
      @(posedge mclk); #1;
      chk("ack_idle", reg_ack, 0);
      chk("rdata_idle", reg_rdata, 0);
      reg_cs = 1; reg_wr = wr; reg_addr = addr; reg_wdata = wd; reg_be = be;
      n = 0;
      do begin
         @(posedge mclk); #1; n++;
      end while (!reg_ack && n < 4);
      chk("ack_latency", n, 1);
      rdo = reg_rdata;
      reg_cs = 0; reg_wr = 0;
   endtask

   task automatic wreg(input int word, input logic [31:0] wd, input logic [3:0] be);
      bus(1'b1, 8'(word * 4), wd, be, rd);
      mwrite(word, wd, be);
   endtask

   task automatic rreg(input string tag, input int word, input logic [31:0] exp);
      bus(1'b0, 8'(word * 4), 32'd0, 4'd0, rd);
      chk(tag, rd, exp);
   endtask

   task automatic check_outputs(input string tag);
      logic [NPAD-1:0] eo, ee;
      int f;
      for (int k = 0; k < NPAD; k++) begin
         f = m_sel[k];
         if (f >= NFUNC) f = 0;
         if (f == 0) begin
            eo[k] = m_gout[k]; ee[k] = !m_goe[k];
         end else begin
            eo[k] = func_out[f*NPAD + k]; ee[k] = func_oeb[f*NPAD + k];
         end
         if (!m_en || (cyc - m_chg[k]) < 2) ee[k] = 1'b1;
      end
      chk({tag, "_out"}, io_out, eo);
      chk({tag, "_oeb"}, io_oeb, ee);
   endtask

   task automatic do_reset();
      reg_cs = 0; reset = 1;
      repeat (2) @(posedge mclk);
      #1;
      reset = 0;
      model_reset();
   endtask

   int wlist[15] = '{0, 4, 5, 6, 7, 8, 9, 12, 13, 14, 15, 18, 19, 2, 31};
   int word, n;
   bit seen;
   logic [31:0] wd;
   logic [3:0] be;

   initial begin
      // Reset state
      repeat (2) @(posedge mclk);
      #1;
      chk("rst_ack", reg_ack, 0);
      chk("rst_rdata", reg_rdata, 0);
      chk("rst_oeb", io_oeb, {NPAD{1'b1}});
      chk("rst_out", io_out, 0);
      chk("rst_pad_in", pad_in, 0);
      reset = 0;
      model_reset();
      rreg("rst_ctrl", 0, 32'h0);
      rreg("rst_sel0", 4, 32'h0);
      rreg("rst_gout", 12, 32'h0);

      // GPIO drive, then switch pad 0 to function 2 and watch the guard
      func_out = '0; func_oeb = '0;
      wreg(0, 32'h1, 4'hF);
      wreg(14, 32'h1, 4'hF);
      wreg(12, 32'h1, 4'hF);
      chk("gpio_out0", io_out[0], 1);
      chk("gpio_oeb0", io_oeb[0], 0);
      wreg(4, 32'h2, 4'hF);
      chk("guard_c1_oeb", io_oeb[0], 1);
      chk("guard_c1_out", io_out[0], 0);
      @(posedge mclk); #1;
      chk("guard_c2_oeb", io_oeb[0], 1);
      @(posedge mclk); #1;
      chk("guard_end_oeb", io_oeb[0], 0);
      chk("guard_end_out", io_out[0], 0);

      // Lock blocks SEL and CTRL writes but still acks
      wreg(1, 32'hA5, 4'h1);
      wreg(4, 32'h1, 4'hF);
      rreg("lock_sel0", 4, 32'h2);
      rreg("lock_rd", 1, 32'h1);
      wreg(0, 32'h0, 4'hF);
      rreg("lock_ctrl", 0, 32'h1);
      do_reset();
      rreg("lock_cleared", 1, 32'h0);

      // Randomized register traffic against the model
      for (int it = 0; it < 150; it++) begin
         for (int i = 0; i < NFUNC*NPAD; i++) begin
            func_out[i] = 1'($urandom);
            func_oeb[i] = 1'($urandom);
         end
         #1;
         check_outputs("rand_mux");
         word = wlist[$urandom_range(0, 14)];
         if ($urandom_range(0, 2) != 0) begin
            wd = $urandom;
            be = 4'($urandom);
            wreg(word, wd, be);
            check_outputs("rand_post");
         end else begin
            rreg("rand_read", word, mread(word));
         end
      end

      // Input path: unfiltered latency and glitch filter
      do_reset();
      wreg(0, 32'h0301, 4'h3);
      wreg(18, 32'h2, 4'hF);
      repeat (8) @(posedge mclk);
      #1;
      io_in[2] = 1;
      @(posedge mclk); #1;
      chk("sync_lat1", pad_in[2], 0);
      @(posedge mclk); #1;
      chk("sync_lat2", pad_in[2], 1);
      io_in[1] = 1;
      @(posedge mclk); #1;
      io_in[1] = 0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge mclk); #1;
         if (pad_in[1]) seen = 1;
      end
      chk("filt_glitch", seen, 0);
      io_in[1] = 1;
      n = 0;
      do begin
         @(posedge mclk); #1; n++;
      end while (!pad_in[1] && n < 16);
      chk("filt_rise", pad_in[1], 1);
      chk("filt_latency_window", (n >= 11 && n <= 14), 1);
      rreg("pad_in_lo", 16, 32'h6);
      rreg("pad_in_hi", 17, 32'h0);

      // Byte enables and pad-count boundary
      wreg(12, 32'h0, 4'hF);
      wreg(12, 32'hFFFF_FFFF, 4'h1);
      rreg("be_gout_lo", 12, 32'h0000_00FF);
      wreg(13, 32'hFFFF_FFFF, 4'hF);
      rreg("gout_hi_bound", 13, 32'h0000_003F);
      wreg(8, 32'hFFFF_FFFF, 4'hF);
      rreg("sel4_bound", 8, 32'h00FF_FFFF);
      rreg("sel5_absent", 9, 32'h0);
      rreg("unmapped_7c", 31, 32'h0);
      #1;
      check_outputs("bound_mux");

      // Reset while a guard is pending
      wreg(4, 32'(m_sel[0] ^ 1), 4'hF);
      chk("mid_guard_oeb", io_oeb[0], 1);
      reset = 1;
      @(posedge mclk); #1;
      chk("rst_mid_oeb", io_oeb, {NPAD{1'b1}});
      chk("rst_mid_ack", reg_ack, 0);
      chk("rst_mid_rdata", reg_rdata, 0);
      reset = 0;
      model_reset();
      rreg("rst_mid_sel0", 4, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
